// File: rtl/data_mem_pkg.sv
// Shared types and default widths for the synchronous data memory.
package data_mem_pkg;

  // Controller states: zeroing the array after reset, or serving requests.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered
// read port. The read register returns zero when no read is enabled, so the
// top can drive its response data straight from it.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Index width covers DEPTH; callers only present in-range addresses.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;
  logic [IDX_W-1:0]  widx_s;
  logic [IDX_W-1:0]  ridx_s;

  assign widx_s = waddr[IDX_W-1:0];
  assign ridx_s = raddr[IDX_W-1:0];
  assign rdata  = rdata_r;

  // Write port: storage has no reset, the top's clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[widx_s] <= wdata;
    end
  end

  // Read port: registered data, zero whenever no read was accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[ridx_s];
    end else begin
      rdata_r <= {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/data_mem_sync.sv
// Synchronous data memory behind a valid/ready request port. Responses come
// one cycle after acceptance; an optional clear sequence zeroes every word
// after reset before any request is taken.
module data_mem_sync
  import data_mem_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  // One extra counter bit so DEPTH = 2^ADDR_W compares without wrapping.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam state_e          INIT_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e            state_r;
  logic [ADDR_W:0]   clr_cnt_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic              accept_s;
  logic              in_range_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              mem_re_s;
  logic [DATA_W-1:0] mem_rdata_s;

  assign req_ready  = (state_r == ST_READY);
  assign busy       = (state_r == ST_CLEAR);
  assign accept_s   = req_valid && req_ready;
  assign in_range_s = ({1'b0, req_addr} < DEPTH_C);

  assign rsp_valid  = rsp_valid_r;
  assign rsp_err    = rsp_err_r;
  assign rsp_rdata  = mem_rdata_s;

  // Write-port mux: clear counter during CLEAR, accepted in-range writes otherwise.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = req_addr;
    mem_wdata_s = req_wdata;
    mem_re_s    = 1'b0;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = rst_n;
      mem_waddr_s = clr_cnt_r[ADDR_W-1:0];
      mem_wdata_s = {DATA_W{1'b0}};
    end else begin
      mem_we_s = rst_n && accept_s && req_wr && in_range_s;
      mem_re_s = accept_s && !req_wr && in_range_s;
    end
  end

  // Controller: clear sequencing, then one-cycle response pulses per request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= INIT_ST;
      clr_cnt_r   <= {(ADDR_W+1){1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_cnt_r   <= clr_cnt_r + ONE_C;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          if (clr_cnt_r == LAST_C) begin
            state_r <= ST_READY;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
        ST_READY: begin
          state_r     <= ST_READY;
          clr_cnt_r   <= clr_cnt_r;
          rsp_valid_r <= accept_s;
          rsp_err_r   <= accept_s && !in_range_s;
        end
        default: begin
          state_r     <= INIT_ST;
          clr_cnt_r   <= {(ADDR_W+1){1'b0}};
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .re    (mem_re_s),
    .raddr (req_addr),
    .rdata (mem_rdata_s)
  );

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: a DEPTH=16 instance checked against an array
// model with random traffic, plus a no-clear instance and a 32-bit instance.
module tb_data_mem_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DEPTH=16, clearing instance
  logic       rst_n, req_valid, req_wr, req_ready, rsp_valid, rsp_err, busy;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  // DEPTH=16, no clear
  logic       n_rst_n, n_req_valid, n_req_wr, n_req_ready, n_rsp_valid, n_rsp_err, n_busy;
  logic [7:0] n_req_addr, n_req_wdata, n_rsp_rdata;
  // DATA_W=32, DEPTH=256
  logic        w_rst_n, w_req_valid, w_req_wr, w_req_ready, w_rsp_valid, w_rsp_err, w_busy;
  logic [7:0]  w_req_addr;
  logic [31:0] w_req_wdata, w_rsp_rdata;

  // Reference model of the DEPTH=16 instance.
  logic [7:0] mem_m [16];
  bit         m_ready;

  data_mem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .CLEAR_ON_RESET(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  data_mem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .CLEAR_ON_RESET(0)) u_dut_nc (
    .clk(clk), .rst_n(n_rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_wr(n_req_wr), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err), .busy(n_busy));

  data_mem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(1)) u_dut_w (
    .clk(clk), .rst_n(w_rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_wr(w_req_wr), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err), .busy(w_busy));

  task automatic model_clear();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
  endtask

  // One request cycle on the main instance, checked against the model.
  task automatic issue(input logic v, input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic       exp_v, exp_e;
    logic [7:0] exp_d;
    checks++;
    if (req_ready !== m_ready || busy !== !m_ready) begin
      errors++;
      $display("FAIL ready_busy: ready=%b busy=%b, expected ready=%b", req_ready, busy, m_ready);
    end
    exp_v = 1'b0; exp_e = 1'b0; exp_d = 8'h00;
    if (v && m_ready) begin
      exp_v = 1'b1;
      if (a >= 8'd16) begin
        exp_e = 1'b1;
      end else if (wr) begin
        mem_m[a[3:0]] = d;
      end else begin
        exp_d = mem_m[a[3:0]];
      end
    end
    req_valid = v; req_wr = wr; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== exp_v || rsp_err !== exp_e || rsp_rdata !== exp_d) begin
      errors++;
      $display("FAIL rsp v=%b wr=%b a=%0d: got valid=%b err=%b rdata=%h, expected valid=%b err=%b rdata=%h",
               v, wr, a, rsp_valid, rsp_err, rsp_rdata, exp_v, exp_e, exp_d);
    end
  endtask

  // Pushes ignored requests while clearing and counts edges until busy drops.
  task automatic wait_clear(input int exp_edges);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < exp_edges + 20) begin
      issue(1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 15)), 8'($urandom_range(1, 255)));
      n++;
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done || n != exp_edges) begin
      errors++;
      $display("FAIL clear_len: busy for %0d edges (done=%b), expected %0d", n, done, exp_edges);
    end
    m_ready = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 8'(i), 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; n_rst_n = 1'b0; w_rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    n_req_valid = 1'b0; n_req_wr = 1'b0; n_req_addr = 8'h00; n_req_wdata = 8'h00;
    w_req_valid = 1'b0; w_req_wr = 1'b0; w_req_addr = 8'h00; w_req_wdata = 32'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_main: ready=%b busy=%b valid=%b err=%b rdata=%h, expected 0 1 0 0 00",
               req_ready, busy, rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if (n_req_ready !== 1'b1 || n_busy !== 1'b0 || n_rsp_valid !== 1'b0 || n_rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_noclear: ready=%b busy=%b valid=%b rdata=%h, expected 1 0 0 00",
               n_req_ready, n_busy, n_rsp_valid, n_rsp_rdata);
    end
    checks++;
    if (w_req_ready !== 1'b0 || w_busy !== 1'b1 || w_rsp_valid !== 1'b0 || w_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_wide: ready=%b busy=%b valid=%b rdata=%h, expected 0 1 0 0",
               w_req_ready, w_busy, w_rsp_valid, w_rsp_rdata);
    end
  endtask

  task automatic test_clear();
    rst_n = 1'b1;
    model_clear();
    wait_clear(16);
    read_all();
  endtask

  task automatic test_write_read();
    issue(1'b1, 1'b1, 8'd3, 8'hA5);
    issue(1'b1, 1'b0, 8'd3, 8'h00);
    issue(1'b1, 1'b1, 8'd7, 8'h3C);
    issue(1'b1, 1'b0, 8'd7, 8'h00);
  endtask

  task automatic test_out_of_range();
    issue(1'b1, 1'b1, 8'd20, 8'hFF);
    issue(1'b1, 1'b0, 8'd20, 8'h00);
    issue(1'b1, 1'b1, 8'd255, 8'h77);
    read_all();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 23)), 8'($urandom));
    end
    read_all();
  endtask

  task automatic test_reset_mid_clear();
    issue(1'b1, 1'b1, 8'd12, 8'h5A);
    // Reset on the edge that would deliver a read response.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'd12; rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b1;
    model_clear();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_drop: valid=%b busy=%b, expected valid=0 busy=1", rsp_valid, busy);
    end
    for (int i = 0; i < 5; i++) issue(1'b1, 1'b1, 8'd12, 8'hC3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear(16);
    read_all();
  endtask

  task automatic test_no_clear();
    n_rst_n = 1'b1;
    checks++;
    if (n_req_ready !== 1'b1 || n_busy !== 1'b0) begin
      errors++;
      $display("FAIL nc_ready: ready=%b busy=%b, expected 1 0", n_req_ready, n_busy);
    end
    n_req_valid = 1'b1; n_req_wr = 1'b1; n_req_addr = 8'd0; n_req_wdata = 8'h11;
    @(posedge clk); #1;
    checks++;
    if (n_rsp_valid !== 1'b1 || n_rsp_err !== 1'b0 || n_rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL nc_write: valid=%b err=%b rdata=%h, expected 1 0 00", n_rsp_valid, n_rsp_err, n_rsp_rdata);
    end
    n_req_wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n_rsp_valid !== 1'b1 || n_rsp_err !== 1'b0 || n_rsp_rdata !== 8'h11) begin
      errors++;
      $display("FAIL nc_read: valid=%b err=%b rdata=%h, expected 1 0 11", n_rsp_valid, n_rsp_err, n_rsp_rdata);
    end
    n_req_addr = 8'd16;
    @(posedge clk); #1;
    checks++;
    if (n_rsp_valid !== 1'b1 || n_rsp_err !== 1'b1 || n_rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL nc_oor: valid=%b err=%b rdata=%h, expected 1 1 00", n_rsp_valid, n_rsp_err, n_rsp_rdata);
    end
    n_req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n_rsp_valid !== 1'b0 || n_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL nc_idle: valid=%b err=%b, expected 0 0", n_rsp_valid, n_rsp_err);
    end
  endtask

  task automatic test_wide();
    int n = 0;
    w_rst_n = 1'b1;
    while (w_busy !== 1'b0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL wide_clear_len: busy for %0d edges, expected 256", n);
    end
    w_req_valid = 1'b1; w_req_wr = 1'b1; w_req_addr = 8'd255; w_req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++;
    if (w_rsp_valid !== 1'b1 || w_rsp_err !== 1'b0 || w_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wide_write: valid=%b err=%b rdata=%h, expected 1 0 0", w_rsp_valid, w_rsp_err, w_rsp_rdata);
    end
    w_req_wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (w_rsp_valid !== 1'b1 || w_rsp_err !== 1'b0 || w_rsp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wide_read: valid=%b err=%b rdata=%h, expected 1 0 deadbeef", w_rsp_valid, w_rsp_err, w_rsp_rdata);
    end
    w_req_addr = 8'd0;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    checks++;
    if (w_rsp_valid !== 1'b1 || w_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wide_read0: valid=%b rdata=%h, expected 1 0", w_rsp_valid, w_rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_out_of_range();
    test_random();
    test_reset_mid_clear();
    test_no_clear();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_sync.md
# data_mem_sync

Parametrised synchronous data memory for the microprocessor datapath, replacing the fixed 8-bit latch-style data store. It holds a single-port RAM behind a valid/ready request interface and returns registered read data one cycle after acceptance. An optional post-reset clear sequencer zeroes every location before the first request is accepted. It sits between the load/store unit and the rest of the core.

## Interface

Parameters:
- `DATA_W`, 8: data word width in bits (≥1).
- `ADDR_W`, 8: address width in bits.
- `DEPTH`, 256: number of words. Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- `CLEAR_ON_RESET`, 1: 1 runs the clear sequence after reset; 0 leaves contents undefined.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted this cycle.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: read data. 0 for writes and errors.
- `rsp_err` out 1: the request address was ≥ DEPTH.
- `busy` out 1: clear sequence in progress.

## Operation

- States are CLEAR and READY.
- **Reset** (rst_n low at a rising edge):
  - state ← CLEAR if CLEAR_ON_RESET=1, else READY.
  - clear counter ← 0.
  - rsp_valid, rsp_rdata and rsp_err ← 0.
- **CLEAR:**
  - Each cycle writes 0 to the location at the clear counter, then increments the counter.
  - After writing DEPTH-1 the state moves to READY.
  - req_ready=0 and busy=1 throughout; requests are ignored.
- **READY:** req_ready=1 and busy=0. A request is accepted when req_valid && req_ready.
- **Accepted write, in range:** mem[req_addr] ← req_wdata. Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- **Accepted read, in range:** next cycle rsp_valid=1, rsp_rdata=mem[req_addr], rsp_err=0.
- **Out-of-range address** (req_addr ≥ DEPTH):
  - No memory write.
  - Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- **No accepted request:** rsp_valid=0 next cycle. rsp_rdata and rsp_err return to 0.
- **Response path:** there is no backpressure; the consumer must take the response on the rsp_valid cycle.
- **Read-after-write:** a read of address A accepted the cycle after a write to A returns the new data.
- **Reset during CLEAR:** the sequence restarts from address 0.
- **Reset while a response is pending:** the response is dropped (rsp_valid=0).
- **Address arithmetic:** req_addr is unsigned. The clear counter is ADDR_W+1 bits wide, so DEPTH = 2^ADDR_W cannot wrap early.

## Timing

- **Reset values:**
  - req_ready: 0 with CLEAR_ON_RESET=1, 1 with CLEAR_ON_RESET=0.
  - busy: 1 with CLEAR_ON_RESET=1, 0 with CLEAR_ON_RESET=0.
  - rsp_valid, rsp_rdata, rsp_err: 0.
- **Clear duration:** busy stays high for exactly DEPTH rising edges after the first edge with rst_n=1. req_ready rises after edge DEPTH (counting that first edge as 1).
- **Latency and throughput:** read and write latency is 1 cycle (request edge → rsp_valid). Throughput is 1 request per cycle, back-to-back.
- **req_ready:** decoded from the state register only. It never depends on req_valid.
- **Output registers:** rsp_* are registered outputs; busy is decoded from the state register.

## Structure

- **Package `data_mem_pkg`:** state enum {CLEAR, READY} and default width constants (DATA_W_DEF=8, ADDR_W_DEF=8).
- **Sub-module `data_mem_array`:**
  - DEPTH×DATA_W storage with one synchronous write port and one synchronous read port.
  - The top level muxes the clear counter or the request onto the write port.
- **Top level:** FSM, clear counter, range check, response registers.

## Test plan

- **Reset clear:** DEPTH=16. Release reset → busy=1 for 16 cycles, req_ready=0. Then read all 16 addresses back-to-back → every rsp_rdata=0, rsp_err=0, one rsp_valid per cycle.
- **Write/read:**
  - Write 0xA5 to address 3 → next cycle rsp_valid=1, rsp_rdata=0.
  - Read address 3 the following cycle → rsp_rdata=0xA5.
  - Back-to-back write 0x3C then read at address 7 → 0x3C.
- **Out of range:** DEPTH=16, ADDR_W=8.
  - Write 0xFF to address 20 → rsp_err=1.
  - Read address 20 → rsp_err=1, rsp_rdata=0.
  - Reads of addresses 0–15 are unchanged.
- **Reset mid-clear:** DEPTH=16. Write a nonzero value at address 12 before reset. Assert rst_n=0 at clear cycle 5 for one cycle → busy stays high 16 more cycles; all reads return 0, including address 12.
- **Ignored requests:** req_valid=1 during CLEAR → no rsp_valid and no memory change.
- **CLEAR_ON_RESET=0:** req_ready=1 immediately after reset. A write 0x11 to address 0 in the first cycle followed by a read of address 0 → 0x11.
- **Width generality:** DATA_W=32, DEPTH=256. Write 0xDEADBEEF to address 255 and read it back → rsp_rdata=0xDEADBEEF, rsp_err=0.
